// File: rtl/dbus_uart.sv
// dbus_uart: data-side bus target for the RV32I core.
// Provides a byte-enabled synchronous RAM (addr[31]==0) and a small MMIO
// block (addr[31]==1): a FIFO-buffered 8N1 UART transmitter and a
// free-running cycle counter. Read data is registered (latency 1).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | line high, waiting for the FIFO to hold a byte
// START | start bit (low) for CLK_DIV cycles
// DATA  | eight data bits, LSB first, CLK_DIV cycles each
// STOP  | stop bit (high); pops the next byte at its end if one is queued

module dbus_uart #(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_write,
    output logic [31:0] mem_rdata,
    output logic        uart_tx
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_DIV);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CYCLE  = 2'd2;

    // ---------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------
    logic          sel_mmio;
    logic [1:0]    reg_sel;
    logic [AW-1:0] ram_idx;
    logic          unused_addr_bits;

    assign sel_mmio = mem_addr[31];
    assign reg_sel  = mem_addr[3:2];
    assign ram_idx  = mem_addr[AW+1:2];
    // Upper RAM address bits alias; byte offset is carried by mem_write.
    assign unused_addr_bits = ^{mem_addr[30:AW+2], mem_addr[1:0]};

    // ---------------------------------------------------------------
    // RAM
    // ---------------------------------------------------------------
    logic [31:0] ram [RAM_WORDS];

    // Byte-lane writes; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (!sel_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_write[i]) begin
                    ram[ram_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // TX FIFO
    // ---------------------------------------------------------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [FW-1:0] wr_ptr;
    logic [FW-1:0] rd_ptr;
    logic [FW:0]   fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          push_ok;
    logic          pop;
    logic [7:0]    fifo_head;

    assign fifo_full  = (fifo_count == (FW+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign push       = sel_mmio && (reg_sel == REG_TXDATA) && mem_write[0];
    // Fullness is judged before this cycle's pop, so a pop never rescues a push.
    assign push_ok    = push && !fifo_full;
    assign fifo_head  = fifo_mem[rd_ptr];

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= mem_wdata[7:0];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + FW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FW'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + (FW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (FW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // UART transmitter
    // ---------------------------------------------------------------
    logic [1:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          baud_end;
    logic          tx_busy;

    assign baud_end = (baud_cnt == CW'(CLK_DIV - 1));
    assign tx_busy  = (state != IDLE);
    // Pop from IDLE immediately, or at the last stop-bit cycle for back-to-back frames.
    assign pop      = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_end));

    // Frame sequencer; uart_tx is registered and updated on state transitions.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            uart_tx  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (pop) begin
                        shift   <= fifo_head;
                        state   <= START;
                        uart_tx <= 1'b0;
                    end else begin
                        uart_tx <= 1'b1;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        uart_tx  <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state   <= STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            uart_tx <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        if (pop) begin
                            shift   <= fifo_head;
                            state   <= START;
                            uart_tx <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            uart_tx <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    uart_tx  <= 1'b1;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Cycle counter
    // ---------------------------------------------------------------
    logic [31:0] cycle_cnt;

    // Free-running, wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // ---------------------------------------------------------------
    // Read path
    // ---------------------------------------------------------------
    logic [31:0] count_ext;
    logic [3:0]  count_sat;
    logic [31:0] status_word;

    assign count_ext   = 32'(fifo_count);
    assign status_word = {20'd0, count_sat, 5'd0, tx_busy, fifo_empty, fifo_full};

    // Occupancy field is only four bits wide; deeper FIFOs saturate it.
    always_comb begin
        count_sat = count_ext[3:0];
        if (count_ext > 32'd15) begin
            count_sat = 4'hF;
        end
    end

    // Registered read mux; RAM reads return the pre-write word.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_rdata <= '0;
        end else if (!sel_mmio) begin
            mem_rdata <= ram[ram_idx];
        end else begin
            case (reg_sel)
                REG_STATUS: mem_rdata <= status_word;
                REG_CYCLE:  mem_rdata <= cycle_cnt;
                default:    mem_rdata <= '0;
            endcase
        end
    end

endmodule
